// File: rtl/ahb_s2m_mux_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ahb_s2m_mux_param                                                 |
// | AHB slave-to-master response mux for NUM_SLAVES slaves with built-in       |
// | default slave; optional wait-state watchdog under `S2M_TIMEOUT_EN.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ahb_s2m_mux_param #(
  parameter int NUM_SLAVES     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] HRESP_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic [RESP_WIDTH-1:0]            HRESP,
  output logic                             HTIMEOUT
);

  localparam logic [RESP_WIDTH-1:0] c_RESP_OKAY  = '0;
  localparam logic [RESP_WIDTH-1:0] c_RESP_ERROR = RESP_WIDTH'(1);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t               r_state;
  ds_state_t               w_state_nxt;
  logic [NUM_SLAVES-1:0]   r_sel_q;
  logic                    w_onehot;
  logic                    w_active;
  logic                    w_sel_any;
  logic                    w_expire;
  logic [DATA_WIDTH-1:0]   w_slv_data;
  logic                    w_slv_ready;
  logic [RESP_WIDTH-1:0]   w_slv_resp;

  assign w_onehot  = (HSEL != '0) && ((HSEL & (HSEL - NUM_SLAVES'(1))) == '0);
  assign w_active  = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign w_sel_any = |r_sel_q;

  // r_sel_q is one-hot or zero, so an OR of the masked slaves is the mux
  always_comb begin
    w_slv_data  = '0;
    w_slv_ready = 1'b0;
    w_slv_resp  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel_q[i]) begin
        w_slv_data  = w_slv_data | HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        w_slv_ready = w_slv_ready | HREADYOUT_S[i];
        w_slv_resp  = w_slv_resp | HRESP_S[i*RESP_WIDTH +: RESP_WIDTH];
      end
    end
  end

  assign HRDATA = w_slv_data;
  assign HREADY = w_sel_any ? w_slv_ready : (r_state != DS_ERR1);
  assign HRESP  = w_sel_any ? w_slv_resp
                            : ((r_state == DS_IDLE) ? c_RESP_OKAY : c_RESP_ERROR);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_q <= '0;
    end else if (w_expire) begin
      r_sel_q <= '0;
    end else if (HREADY) begin
      r_sel_q <= w_onehot ? HSEL : '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= DS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ERR2 reuses the IDLE rule so consecutive bad transfers chain ERR1/ERR2
  always_comb begin
    w_state_nxt = r_state;
    if (w_expire) begin
      w_state_nxt = DS_ERR1;
    end else begin
      case (r_state)
        DS_ERR1: w_state_nxt = DS_ERR2;
        default: begin
          if (HREADY) begin
            w_state_nxt = (w_active && !w_onehot) ? DS_ERR1 : DS_IDLE;
          end
        end
      endcase
    end
  end

`ifdef S2M_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;

  assign w_expire = w_sel_any && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES));
  assign HTIMEOUT = w_expire;

  // HREADY low with a slave selected means that slave is inserting waits
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tmo_cnt <= '0;
    end else if (w_expire || HREADY) begin
      r_tmo_cnt <= '0;
    end else if (w_sel_any) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end
`else
  logic w_unused_tmo;

  assign w_expire     = 1'b0;
  assign HTIMEOUT     = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_s2m_mux_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ahb_s2m_mux_param                                              |
// | Directed and randomized bench for ahb_s2m_mux_param with a data-phase      |
// | transaction model.                                                         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ahb_s2m_mux_param;

  localparam int N   = 3;
  localparam int TMO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [N-1:0]  HSEL;
  logic [1:0]    HTRANS;
  logic [N*32-1:0] HRDATA_S;
  logic [N-1:0]  HREADYOUT_S;
  logic [N*2-1:0] HRESP_S;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic          HTIMEOUT;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  ahb_s2m_mux_param #(
    .NUM_SLAVES(N), .DATA_WIDTH(32), .RESP_WIDTH(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HTIMEOUT(HTIMEOUT)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: what kind of data phase the master is currently in
  typedef enum int {PH_OKAY, PH_SLV, PH_ERR1, PH_ERR2} phase_t;
  phase_t ph = PH_OKAY;
  int     m_slv = 0;
  int     m_stall = 0;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic e_ready();
    case (ph)
      PH_SLV:  return HREADYOUT_S[m_slv];
      PH_ERR1: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] e_resp();
    case (ph)
      PH_SLV:           return HRESP_S[m_slv*2 +: 2];
      PH_ERR1, PH_ERR2: return 2'b01;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] e_data();
    return (ph == PH_SLV) ? HRDATA_S[m_slv*32 +: 32] : 32'h0;
  endfunction

  function automatic logic e_tmo();
`ifdef S2M_TIMEOUT_EN
    return (ph == PH_SLV) && (m_stall == TMO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph      <= PH_OKAY;
      m_stall <= 0;
    end else if (e_tmo()) begin
      ph      <= PH_ERR1;
      m_stall <= 0;
    end else if (ph == PH_ERR1) begin
      ph <= PH_ERR2;
    end else if (e_ready()) begin
      m_stall <= 0;
      if ($countones(HSEL) == 1) begin
        ph    <= PH_SLV;
        m_slv <= oh_idx(HSEL);
      end else if (HTRANS[1]) begin
        ph <= PH_ERR1;
      end else begin
        ph <= PH_OKAY;
      end
    end else begin
      m_stall <= m_stall + 1;
    end
  end

  always @(negedge HCLK) begin
    if (chk_en && HRESETn === 1'b1) begin
      check("mdl_hrdata", HRDATA, e_data());
      check("mdl_hready", {31'h0, HREADY}, {31'h0, e_ready()});
      check("mdl_hresp", {30'h0, HRESP}, {30'h0, e_resp()});
      check("mdl_htimeout", {31'h0, HTIMEOUT}, {31'h0, e_tmo()});
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic neg();
    @(negedge HCLK);
  endtask

  task automatic drive(input logic [1:0] t, input logic [N-1:0] s);
    HTRANS = t;
    HSEL   = s;
  endtask

  initial begin
    int  k;
    bit  found;
    bit  bad;
    int  r;
    HRESETn     = 1'b0;
    HSEL        = '0;
    HTRANS      = 2'b00;
    HRDATA_S    = {32'h33333333, 32'hCAFEF00D, 32'h11111111};
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    #3;
    check("rst_hready", {31'h0, HREADY}, 32'h1);
    check("rst_hresp", {30'h0, HRESP}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_htimeout", {31'h0, HTIMEOUT}, 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    chk_en  = 1'b1;
    neg();
    check("post_rst_okay", {29'h0, HREADY, HRESP}, 32'h4);

    // Slave index 1 with two wait states; HSEL moves during the waits
    tick(); drive(2'b10, 3'b010);
    tick(); drive(2'b10, 3'b100); HREADYOUT_S[1] = 1'b0;
    neg();  check("wait1_hready", {31'h0, HREADY}, 32'h0);
    tick(); neg(); check("wait2_hready", {31'h0, HREADY}, 32'h0);
    tick(); drive(2'b00, 3'b000); HREADYOUT_S[1] = 1'b1;
    neg();  check("wait_done_data", HRDATA, 32'hCAFEF00D);
    check("wait_done_rdy_resp", {29'h0, HREADY, HRESP}, 32'h4);

    // Unselected NONSEQ, then IDLE
    tick(); drive(2'b10, 3'b000);
    tick(); drive(2'b00, 3'b000);
    neg();  check("err1", {29'h0, HREADY, HRESP}, 32'h1);
    tick(); neg(); check("err2", {29'h0, HREADY, HRESP}, 32'h5);
    tick(); neg(); check("idle_okay", {29'h0, HREADY, HRESP}, 32'h4);

    // Multi-hot select, then a valid NONSEQ issued during ERR2
    tick(); drive(2'b10, 3'b011);
    tick(); drive(2'b00, 3'b000);
    neg();  check("mh_err1", {29'h0, HREADY, HRESP}, 32'h1);
    tick(); drive(2'b10, 3'b100);
    neg();  check("mh_err2", {29'h0, HREADY, HRESP}, 32'h5);
    tick(); drive(2'b00, 3'b000);
    neg();  check("mh_then_s3", HRDATA, 32'h33333333);

    // Back-to-back 1 -> 3 -> 1
    tick(); drive(2'b10, 3'b001);
    tick(); drive(2'b11, 3'b100);
    neg();  check("b2b_s1a", HRDATA, 32'h11111111);
    tick(); drive(2'b10, 3'b001);
    neg();  check("b2b_s3", HRDATA, 32'h33333333);
    tick(); drive(2'b00, 3'b000);
    neg();  check("b2b_s1b", HRDATA, 32'h11111111);

    // Asynchronous reset during a slave wait state
    tick(); drive(2'b10, 3'b010);
    tick(); drive(2'b00, 3'b000); HREADYOUT_S[1] = 1'b0;
    neg();  check("pre_rst_stall", {31'h0, HREADY}, 32'h0);
    #1 HRESETn = 1'b0;
    #1;
    check("arst_hready", {31'h0, HREADY}, 32'h1);
    check("arst_hresp", {30'h0, HRESP}, 32'h0);
    check("arst_hrdata", HRDATA, 32'h0);
    tick(); tick();
    HRESETn = 1'b1;
    HREADYOUT_S = '1;
    neg();  check("post_arst_okay", {29'h0, HREADY, HRESP}, 32'h4);

    // Slave index 0 stuck not-ready
    tick(); drive(2'b10, 3'b001);
    tick(); drive(2'b00, 3'b000); HREADYOUT_S[0] = 1'b0;
`ifdef S2M_TIMEOUT_EN
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      neg();
      k++;
      if (HTIMEOUT === 1'b1) found = 1'b1;
      else tick();
    end
    check("tmo_cycle", k, 32'd5);
    tick(); neg(); check("tmo_err1", {29'h0, HREADY, HRESP}, 32'h1);
    tick(); neg(); check("tmo_err2", {29'h0, HREADY, HRESP}, 32'h5);
    HREADYOUT_S[0] = 1'b1;
`else
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      neg();
      if (HREADY !== 1'b0 || HTIMEOUT !== 1'b0) bad = 1'b1;
      tick();
    end
    check("stall_100", {31'h0, bad}, 32'h0);
    HREADYOUT_S[0] = 1'b1;
    neg();  check("stall_release", HRDATA, 32'h11111111);
`endif

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      r = $urandom_range(0, 9);
      if (r < 7)       HSEL = N'(1) << $urandom_range(0, N-1);
      else if (r == 7) HSEL = '0;
      else             HSEL = N'($urandom_range(0, (1 << N) - 1));
      HTRANS = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        HRDATA_S[i*32 +: 32] = $urandom;
        HREADYOUT_S[i]       = ($urandom_range(0, 3) != 0);
        HRESP_S[i*2 +: 2]    = 2'($urandom_range(0, 1));
      end
    end
    tick();
    neg();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
